// File: rtl/lfsr_weight_update.sv
// lfsr_weight_update: stochastic synaptic weight counter.
// An accepted update request is resolved one cycle later by comparing its
// probability against a free-running 7-bit LFSR draw; a successful draw
// moves the weight one step in the requested direction, saturating at 0
// and at the maximum.
//
// Handshake: an update transfers on a rising edge where upd_valid and
// upd_ready are both 1. upd_ready depends only on internal state (never on
// upd_valid), prob and inc are sampled only on that transfer edge, and a
// request that does not transfer is simply not seen by the block.
module lfsr_weight_update #(
    parameter int         WEIGHT_W  = 3,
    parameter logic [6:0] LFSR_SEED = 7'h01
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                upd_valid,
    input  logic [6:0]          prob,
    input  logic                inc,
    output logic                upd_ready,
    input  logic                w_load,
    input  logic [WEIGHT_W-1:0] w_init,
    output logic [WEIGHT_W-1:0] weight,
    output logic                done,
    output logic                fired,
    output logic                sat,
    output logic [6:0]          lfsr_dbg,
    output logic                state_dbg
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [6:0] SEED = (LFSR_SEED == 7'h00) ? 7'h01 : LFSR_SEED;
    localparam logic [WEIGHT_W-1:0] W_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [6:0]          lfsr_q;
    logic [6:0]          prob_q;
    logic                inc_q;
    logic                capture;
    logic                fire;
    logic [WEIGHT_W-1:0] weight_d;
    logic                done_d;
    logic                fired_d;
    logic                sat_d;

    assign upd_ready = (state_q == IDLE);
    assign lfsr_dbg  = lfsr_q;
    assign state_dbg = (state_q == DRAW);

    // Free-running Fibonacci LFSR, x^7 + x^6 + 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request parameters on an accepted transfer only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prob_q <= 7'h00;
            inc_q  <= 1'b0;
        end else if (capture) begin
            prob_q <= prob;
            inc_q  <= inc;
        end
    end

    // Next state, draw decision and weight arithmetic.
    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        weight_d = weight;
        done_d   = 1'b0;
        fired_d  = 1'b0;
        sat_d    = 1'b0;
        // 127 means certain; otherwise the LFSR (never 0) must fall below prob.
        fire     = (prob_q == 7'h7F) || (lfsr_q < prob_q);
        case (state_q)
            IDLE: begin
                if (upd_valid) begin
                    capture = 1'b1;
                    state_d = DRAW;
                end
            end
            DRAW: begin
                state_d = IDLE;
                // A weight load during the draw aborts the pending update.
                if (!w_load) begin
                    done_d = 1'b1;
                    if (fire) begin
                        fired_d = 1'b1;
                        if (inc_q && (weight != W_MAX)) begin
                            weight_d = weight + 1'b1;
                        end else if (!inc_q && (weight != '0)) begin
                            weight_d = weight - 1'b1;
                        end else begin
                            sat_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (w_load) begin
            weight_d = w_init;
        end
    end

    // Registered weight and the one-cycle result strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight <= '0;
            done   <= 1'b0;
            fired  <= 1'b0;
            sat    <= 1'b0;
        end else begin
            weight <= weight_d;
            done   <= done_d;
            fired  <= fired_d;
            sat    <= sat_d;
        end
    end

endmodule

// File: tb/tb_lfsr_weight_update.sv
// Bench for lfsr_weight_update: hand-derived vector table, directed
// multi-cycle sequences, and a long randomized run against a queue-based
// reference model.
module tb_lfsr_weight_update;

    localparam int         WW   = 3;
    localparam int         WMAX = 7;
    localparam logic [6:0] SEED = 7'h01;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          upd_valid = 1'b0;
    logic [6:0]    prob = 7'h00;
    logic          inc = 1'b0;
    logic          w_load = 1'b0;
    logic [WW-1:0] w_init = '0;
    logic          upd_ready;
    logic [WW-1:0] weight;
    logic          done;
    logic          fired;
    logic          sat;
    logic [6:0]    lfsr_dbg;
    logic          state_dbg;

    int checks = 0;
    int failures = 0;

    lfsr_weight_update #(
        .WEIGHT_W  (WW),
        .LFSR_SEED (SEED)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .upd_valid (upd_valid),
        .prob      (prob),
        .inc       (inc),
        .upd_ready (upd_ready),
        .w_load    (w_load),
        .w_init    (w_init),
        .weight    (weight),
        .done      (done),
        .fired     (fired),
        .sat       (sat),
        .lfsr_dbg  (lfsr_dbg),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // exp_q holds the outstanding accepted request as {inc, will_fire}; the
    // draw outcome is decided at acceptance from the LFSR value that the
    // following cycle will hold.
    logic [1:0] exp_q[$];
    int         m_lfsr;
    int         m_weight;
    int         m_done;
    int         m_fired;
    int         m_sat;

    function automatic int lfsr_next(input int q);
        return ((q * 2) % 128) + ((((q / 64) % 2) + ((q / 32) % 2)) % 2);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_lfsr   = SEED;
        m_weight = 0;
        m_done   = 0;
        m_fired  = 0;
        m_sat    = 0;
    endtask

    task automatic model_edge();
        logic [1:0] ent;
        int         draw;
        int         p;
        m_done  = 0;
        m_fired = 0;
        m_sat   = 0;
        if (exp_q.size() != 0) begin
            ent = exp_q.pop_front();
            if (!w_load) begin
                m_done = 1;
                if (ent[0]) begin
                    m_fired = 1;
                    if (ent[1] && m_weight < WMAX)    m_weight = m_weight + 1;
                    else if (!ent[1] && m_weight > 0) m_weight = m_weight - 1;
                    else                              m_sat = 1;
                end
            end
        end else if (upd_valid) begin
            draw = lfsr_next(m_lfsr);
            p    = int'(prob);
            exp_q.push_back({inc, (p == 127) || (draw < p)});
        end
        if (w_load) m_weight = int'(w_init);
        m_lfsr = lfsr_next(m_lfsr);
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs now on the pins, then
    // compare every output just after the edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        chk("weight", int'(weight), m_weight);
        chk("done", int'(done), m_done);
        chk("fired", int'(fired), m_fired);
        chk("sat", int'(sat), m_sat);
        chk("upd_ready", int'(upd_ready), (exp_q.size() == 0) ? 1 : 0);
        chk("lfsr", int'(lfsr_dbg), m_lfsr);
    endtask

    task automatic do_reset();
        upd_valid = 1'b0;
        w_load    = 1'b0;
        prob      = 7'h00;
        inc       = 1'b0;
        rst       = 1'b1;
        #2;
        chk("rst_weight", int'(weight), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_fired", int'(fired), 0);
        chk("rst_sat", int'(sat), 0);
        chk("rst_ready", int'(upd_ready), 1);
        chk("rst_lfsr", int'(lfsr_dbg), 1);
        chk("rst_state", int'(state_dbg), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    // Without a load the accept happens in the first cycle after reset and
    // the draw sees LFSR 0x02; with a load first the draw sees 0x04.
    typedef struct {
        bit          use_load;
        int          w_init;
        int          prob;
        bit          inc;
        int          exp_fired;
        int          exp_sat;
        int          exp_weight;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int nd;
        int nf;
        int ns;
        int seq[7];
        int sel;

        vecs[0] = '{0, 0, 3,   1'b1, 1, 0, 1};
        vecs[1] = '{0, 0, 2,   1'b1, 0, 0, 0};
        vecs[2] = '{1, 0, 127, 1'b0, 1, 1, 0};
        vecs[3] = '{1, 7, 127, 1'b1, 1, 1, 7};
        vecs[4] = '{1, 4, 5,   1'b0, 1, 0, 3};
        vecs[5] = '{1, 4, 4,   1'b0, 0, 0, 4};
        vecs[6] = '{1, 3, 0,   1'b1, 0, 0, 3};
        vecs[7] = '{1, 6, 126, 1'b1, 1, 0, 7};
        seq = '{1, 2, 4, 8, 16, 32, 65};

        #1;
        // ---- table-driven single transactions ----
        for (int i = 0; i < 8; i++) begin
            do_reset();
            if (vecs[i].use_load) begin
                w_load = 1'b1;
                w_init = WW'(vecs[i].w_init);
                cycle();
                w_load = 1'b0;
            end
            upd_valid = 1'b1;
            prob      = 7'(vecs[i].prob);
            inc       = vecs[i].inc;
            cycle();
            chk("tbl_draw_ready", int'(upd_ready), 0);
            chk("tbl_draw_done", int'(done), 0);
            // Held-high valid and changing prob/inc must be ignored in DRAW.
            prob = 7'($urandom_range(0, 127));
            inc  = 1'($urandom_range(0, 1));
            cycle();
            upd_valid = 1'b0;
            chk("tbl_done", int'(done), 1);
            chk("tbl_fired", int'(fired), vecs[i].exp_fired);
            chk("tbl_sat", int'(sat), vecs[i].exp_sat);
            chk("tbl_weight", int'(weight), vecs[i].exp_weight);
            cycle();
            chk("tbl_done_clear", int'(done), 0);
        end

        // ---- load during DRAW aborts the update ----
        do_reset();
        w_load = 1'b1;
        w_init = 3'd2;
        cycle();
        w_load    = 1'b0;
        upd_valid = 1'b1;
        prob      = 7'd127;
        inc       = 1'b1;
        cycle();
        upd_valid = 1'b0;
        w_load    = 1'b1;
        w_init    = 3'd5;
        cycle();
        w_load = 1'b0;
        chk("abort_weight", int'(weight), 5);
        chk("abort_done", int'(done), 0);
        chk("abort_ready", int'(upd_ready), 1);
        cycle();
        chk("abort_no_late_done", int'(done), 0);

        // ---- reset during DRAW ----
        do_reset();
        w_load = 1'b1;
        w_init = 3'd3;
        cycle();
        w_load    = 1'b0;
        upd_valid = 1'b1;
        prob      = 7'd127;
        inc       = 1'b1;
        cycle();
        upd_valid = 1'b0;
        rst       = 1'b1;
        #1;
        chk("rstdraw_weight", int'(weight), 0);
        chk("rstdraw_done", int'(done), 0);
        chk("rstdraw_fired", int'(fired), 0);
        chk("rstdraw_sat", int'(sat), 0);
        chk("rstdraw_lfsr", int'(lfsr_dbg), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rstdraw_ready", int'(upd_ready), 1);
        for (int i = 0; i < 7; i++) begin
            chk("lfsr_seq", int'(lfsr_dbg), seq[i]);
            chk("rstdraw_no_done", int'(done), 0);
            cycle();
        end

        // ---- prob=0 back-to-back: never fires ----
        do_reset();
        upd_valid = 1'b1;
        prob      = 7'd0;
        nd = 0;
        nf = 0;
        for (int i = 0; i < 400; i++) begin
            inc = 1'($urandom_range(0, 1));
            cycle();
            chk("p0_pulse_period", int'(done), i % 2);
            nd += int'(done);
            nf += int'(fired);
        end
        chk("p0_done_count", nd, 200);
        chk("p0_fired_count", nf, 0);
        chk("p0_weight", int'(weight), 0);

        // ---- prob=127 increments: saturate at max ----
        prob = 7'd127;
        inc  = 1'b1;
        nd = 0;
        ns = 0;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (done) begin
                nd++;
                ns += int'(sat);
                if (nd == 7) chk("p127_weight_at_7", int'(weight), 7);
            end
        end
        upd_valid = 1'b0;
        chk("p127_done_count", nd, 200);
        chk("p127_sat_count", ns, 193);
        chk("p127_weight_final", int'(weight), 7);

        // ---- fire rate for prob=64 over full LFSR periods ----
        do_reset();
        upd_valid = 1'b1;
        prob      = 7'd64;
        nd = 0;
        nf = 0;
        for (int i = 0; i < 508; i++) begin
            inc = 1'($urandom_range(0, 1));
            cycle();
            if (done) begin
                nd++;
                nf += int'(fired);
            end
        end
        upd_valid = 1'b0;
        chk("rate_done_count", nd, 254);
        chk("rate_within_2pct",
            ((nf * 127 - 64 * nd) * 100 <= 2 * 127 * nd) &&
            ((64 * nd - nf * 127) * 100 <= 2 * 127 * nd) ? 1 : 0, 1);

        // ---- randomized run against the reference model ----
        do_reset();
        for (int i = 0; i < 40000; i++) begin
            upd_valid = ($urandom_range(0, 9) < 7);
            sel = $urandom_range(0, 9);
            if (sel == 0)      prob = 7'd0;
            else if (sel == 1) prob = 7'd127;
            else               prob = 7'($urandom_range(0, 127));
            inc    = 1'($urandom_range(0, 1));
            w_load = !upd_valid && ($urandom_range(0, 49) == 0);
            w_init = WW'($urandom_range(0, WMAX));
            cycle();
        end
        upd_valid = 1'b0;
        w_load    = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
